// File: rtl/cpu_controller.sv
// ---------------------------------------------------------------------------
// cpu_controller
//   Eight-phase fetch/decode/execute sequencer for the 8-bit accumulator CPU.
//   Decodes the 3-bit opcode, sequences memory reads/writes and drives the
//   PC, IR and ACC load strobes. The ALU is_zero flag resolves SKZ.
//
// Parameters
//   HALT_STICKY  1: HLT parks the sequencer in a halted state until reset
//                0: halt pulses for one phase and fetching continues
//
// Ports
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   en      in   phase-advance enable (0 freezes the phase and its decode)
//   opcode  in   IR[7:5], meaningful from phase OP_ADDR onward
//   zero    in   ALU is_zero flag (equals ACC==0 while SKZ executes)
//   sel     out  address mux: 1 = PC, 0 = IR operand address
//   rd      out  memory read enable
//   ld_ir   out  load instruction register
//   inc_pc  out  PC increment strobe
//   ld_pc   out  PC parallel load (jump target)
//   ld_ac   out  accumulator load
//   wr      out  memory write strobe
//   data_e  out  drive ACC onto the data bus
//   halt    out  HLT indication
//   phase   out  current phase index (debug view of the FSM), 7 while halted
//
// Handshake: there is no valid/ready pair here; en is a plain qualifier.
// The phase advances only on a rising clk edge sampled with en=1, and all
// strobes are a pure combinational decode of the registered state, so they
// stay asserted for as long as en holds the phase.
// ---------------------------------------------------------------------------
module cpu_controller #(
   parameter logic HALT_STICKY = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic       halt,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   localparam logic [2:0] OP_HLT = 3'b000;
   localparam logic [2:0] OP_SKZ = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDA = 3'b101;
   localparam logic [2:0] OP_STO = 3'b110;
   localparam logic [2:0] OP_JMP = 3'b111;

   phase_t phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   is_aluop, is_skz, is_sto, is_jmp, is_hlt;

   // Opcode classes; only consumed in phases OP_ADDR..STORE so an undefined
   // opcode during fetch cannot reach the outputs.
   assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);
   assign is_skz   = (opcode == OP_SKZ);
   assign is_sto   = (opcode == OP_STO);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_hlt   = (opcode == OP_HLT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      sel      = 1'b0;
      rd       = 1'b0;
      ld_ir    = 1'b0;
      inc_pc   = 1'b0;
      ld_pc    = 1'b0;
      ld_ac    = 1'b0;
      wr       = 1'b0;
      data_e   = 1'b0;
      halt     = 1'b0;
      phase    = phase_q;

      if (halted_q) begin
         // Parked: everything quiet except halt; only rst_n leaves this.
         halt  = 1'b1;
         phase = 3'd7;
      end else begin
         if (en) begin
            if (HALT_STICKY && (phase_q == OP_ADDR) && is_hlt) begin
               halted_d = 1'b1;
               phase_d  = STORE;
            end else begin
               phase_d = phase_t'(phase_q + 3'd1);
            end
         end

         case (phase_q)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = is_hlt;
            end
            OP_FETCH: begin
               rd = is_aluop;
            end
            ALU_OP: begin
               rd     = is_aluop;
               // Second PC increment skips the next instruction.
               inc_pc = is_skz & zero;
               ld_pc  = is_jmp;
               data_e = is_sto;
            end
            STORE: begin
               rd     = is_aluop;
               ld_ac  = is_aluop;
               ld_pc  = is_jmp;
               wr     = is_sto;
               data_e = is_sto;
            end
            default: begin
               sel = 1'b1;
            end
         endcase
      end
   end

endmodule
